// File: rtl/shift_sequencer_pkg.sv
// Purpose: shared constants and state encoding for the multi-cycle shift sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package shift_sequencer_pkg;

    localparam int SHIFT_WIDTH   = 32;
    localparam int SHIFT_NSTAGES = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic OP_SLL = 1'b0;
    localparam logic OP_SRA = 1'b1;

endpackage

// File: rtl/shift_stage.sv
// Purpose: one shared power-of-two shift stage; amount is 16 >> step, direction SLL or SRA.
// Latency: combinational.
// Backpressure: none.
// Ports: data (operand), step (0..4 selects 16/8/4/2/1), sra (OP_SLL/OP_SRA), result (shifted data).
module shift_stage
    import shift_sequencer_pkg::*;
(
    input  logic [31:0] data,
    input  logic [2:0]  step,
    input  logic        sra,
    output logic [31:0] result
);

    // Fixed-amount left stages: zero fill from the bottom.
    logic [31:0] sll_16, sll_8, sll_4, sll_2, sll_1;
    // Fixed-amount right stages: sign fill from bit 31.
    logic [31:0] sra_16, sra_8, sra_4, sra_2, sra_1;
    logic [31:0] left_out;
    logic [31:0] right_out;

    assign sll_16 = {data[15:0], 16'h0000};
    assign sll_8  = {data[23:0], 8'h00};
    assign sll_4  = {data[27:0], 4'h0};
    assign sll_2  = {data[29:0], 2'b00};
    assign sll_1  = {data[30:0], 1'b0};

    assign sra_16 = {{16{data[31]}}, data[31:16]};
    assign sra_8  = {{8{data[31]}},  data[31:8]};
    assign sra_4  = {{4{data[31]}},  data[31:4]};
    assign sra_2  = {{2{data[31]}},  data[31:2]};
    assign sra_1  = {data[31],       data[31:1]};

    always_comb begin
        left_out  = data;
        right_out = data;
        case (step)
            3'd0: begin left_out = sll_16; right_out = sra_16; end
            3'd1: begin left_out = sll_8;  right_out = sra_8;  end
            3'd2: begin left_out = sll_4;  right_out = sra_4;  end
            3'd3: begin left_out = sll_2;  right_out = sra_2;  end
            3'd4: begin left_out = sll_1;  right_out = sra_1;  end
            default: begin left_out = data; right_out = data; end
        endcase
    end

    always_comb begin
        result = data;
        case (sra)
            OP_SLL:  result = left_out;
            OP_SRA:  result = right_out;
            default: result = data;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Purpose: 32-bit SLL/SRA done as five passes through one shared stage, MSB of amount first.
// Latency: fixed 5 cycles from accepted start to data_resultRDY (shiftamt = 0 included).
// Backpressure: none; busy is high while shifting and any start seen then is dropped, not queued.
// Ports: clock/reset (async, active-high); ctrl_start/ctrl_sra/ctrl_shiftamt/data_operandA request;
//        data_result (held until next accepted start), data_resultRDY (1-cycle pulse), busy.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH   = SHIFT_WIDTH,
    parameter int NSTAGES = SHIFT_NSTAGES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_start,
    input  logic             ctrl_sra,
    input  logic [4:0]       ctrl_shiftamt,
    input  logic [WIDTH-1:0] data_operandA,
    output logic [WIDTH-1:0] data_result,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam logic [2:0] LAST_STEP = 3'(NSTAGES - 1);

    state_t           state;
    logic [2:0]       step;
    logic [4:0]       amt_q;
    logic             sra_q;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] stage_out;
    logic [2:0]       bit_idx;

    shift_stage u_stage (
        .data   (work_q),
        .step   (step),
        .sra    (sra_q),
        .result (stage_out)
    );

    // Step 0 uses amount bit 4 (shift by 16), step 4 uses bit 0 (shift by 1).
    assign bit_idx = LAST_STEP - step;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            step   <= 3'd0;
            amt_q  <= 5'd0;
            sra_q  <= OP_SLL;
            work_q <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (ctrl_start) begin
                        work_q <= data_operandA;
                        amt_q  <= ctrl_shiftamt;
                        sra_q  <= ctrl_sra;
                        step   <= 3'd0;
                        state  <= S_SHIFT;
                    end else begin
                        state  <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    if (amt_q[bit_idx]) begin
                        work_q <= stage_out;
                    end
                    step <= step + 3'd1;
                    if (step == LAST_STEP) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    step  <= 3'd0;
                end
            endcase
        end
    end

    // Pure decodes of registered state: no input-to-output path.
    assign data_result    = work_q;
    assign data_resultRDY = (state == S_DONE);
    assign busy           = (state == S_SHIFT);

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

    logic        clock;
    logic        reset;
    logic        ctrl_start;
    logic        ctrl_sra;
    logic [4:0]  ctrl_shiftamt;
    logic [31:0] data_operandA;
    logic [31:0] data_result;
    logic        data_resultRDY;
    logic        busy;

    int n_chk = 0;
    int n_bad = 0;
    int n_start = 0;
    int rdy_cnt = 0;
    logic [31:0] exp_q[$];

    shift_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_start     (ctrl_start),
        .ctrl_sra       (ctrl_sra),
        .ctrl_shiftamt  (ctrl_shiftamt),
        .data_operandA  (data_operandA),
        .data_result    (data_result),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic s, input logic [4:0] amt);
        if (s) return 32'($signed(a) >>> amt);
        else   return a << amt;
    endfunction

    // Scoreboard: every RDY pulse consumes one expected result.
    always @(negedge clock) begin
        if (data_resultRDY) begin
            rdy_cnt++;
            if (exp_q.size() == 0) chk_eq("unexpected_rdy", 32'd1, 32'd0);
            else                   chk_eq("result", data_result, exp_q.pop_front());
        end
    end

    // One operation: start is held for one edge, then inputs are scrambled while
    // shifting. glitch_k > 0 re-pulses start (with junk operands) during SHIFT.
    task automatic run_op(input logic [31:0] a, input logic s, input logic [4:0] amt,
                          input logic [31:0] exp_v, input int glitch_k);
        int  nb;
        int  lat;
        bit  seen;
        nb = 0; lat = 0; seen = 0;
        @(negedge clock);
        ctrl_start = 1'b1; ctrl_sra = s; ctrl_shiftamt = amt; data_operandA = a;
        exp_q.push_back(exp_v);
        n_start++;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (k == 1) begin
                ctrl_start    = 1'b0;
                data_operandA = $urandom;
                ctrl_shiftamt = 5'($urandom_range(0, 31));
                ctrl_sra      = 1'($urandom_range(0, 1));
            end
            if (glitch_k > 0 && k == glitch_k) begin
                ctrl_start    = 1'b1;
                data_operandA = $urandom;
                ctrl_shiftamt = 5'($urandom_range(0, 31));
            end
            if (glitch_k > 0 && k == glitch_k + 1) ctrl_start = 1'b0;
            if (busy) nb++;
            if (data_resultRDY) begin
                seen = 1; lat = k;
                break;
            end
        end
        chk_eq("rdy_seen", 32'(seen), 32'd1);
        chk_eq("latency", lat, 6);
        chk_eq("busy_cycles", nb, 5);
        @(negedge clock);
        chk_eq("rdy_low_after", 32'(data_resultRDY), 32'd0);
        chk_eq("result_hold", data_result, exp_v);
    endtask

    initial begin
        int gap;
        bit seen2;
        logic [31:0] ra;
        logic [4:0]  ramt;
        logic        rs;

        reset = 1'b1; ctrl_start = 1'b0; ctrl_sra = 1'b0;
        ctrl_shiftamt = 5'd0; data_operandA = 32'h0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk_eq("reset_result", data_result, 32'h0);
        chk_eq("reset_rdy", 32'(data_resultRDY), 32'd0);
        chk_eq("reset_busy", 32'(busy), 32'd0);

        // Directed cases
        run_op(32'h80000000, 1'b1, 5'd16, 32'hFFFF8000, 0);
        run_op(32'h00000001, 1'b0, 5'd31, 32'h80000000, 0);
        run_op(32'h12345678, 1'b0, 5'd0,  32'h12345678, 0);
        run_op(32'h7FFFFFFF, 1'b1, 5'd31, 32'h00000000, 0);
        run_op(32'h80000000, 1'b1, 5'd31, 32'hFFFFFFFF, 0);

        // Start re-pulsed mid-shift is ignored
        run_op(32'hDEADBEEF, 1'b0, 5'd4, 32'hEADBEEF0, 2);

        // Back-to-back: second start issued in the DONE cycle
        @(negedge clock);
        ctrl_start = 1'b1; ctrl_sra = 1'b0; ctrl_shiftamt = 5'd31; data_operandA = 32'h00000001;
        exp_q.push_back(32'h80000000);
        n_start++;
        seen2 = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (k == 1) ctrl_start = 1'b0;
            if (data_resultRDY) begin seen2 = 1; break; end
        end
        chk_eq("b2b_first_rdy", 32'(seen2), 32'd1);
        ctrl_start = 1'b1; ctrl_sra = 1'b1; ctrl_shiftamt = 5'd4; data_operandA = 32'h87654321;
        exp_q.push_back(32'hF8765432);
        n_start++;
        gap = 0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clock);
            if (j == 1) begin
                ctrl_start = 1'b0;
                chk_eq("b2b_no_bubble", 32'(busy), 32'd1);
            end
            if (data_resultRDY) begin gap = j; break; end
        end
        // Five non-RDY cycles separate the two pulses.
        chk_eq("b2b_gap", gap, 6);

        // Async reset during step 2 discards the op
        @(negedge clock);
        ctrl_start = 1'b1; ctrl_sra = 1'b1; ctrl_shiftamt = 5'd5; data_operandA = 32'hF0F0F0F0;
        @(negedge clock);
        ctrl_start = 1'b0;
        repeat (2) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk_eq("async_rst_result", data_result, 32'h0);
        chk_eq("async_rst_busy", 32'(busy), 32'd0);
        chk_eq("async_rst_rdy", 32'(data_resultRDY), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        chk_eq("no_rdy_after_abort", rdy_cnt, n_start);
        run_op(32'hF0F0F0F0, 1'b1, 5'd5, 32'hFF878787, 0);

        // Random sweep
        for (int i = 0; i < 500; i++) begin
            ra   = $urandom;
            ramt = 5'($urandom_range(0, 31));
            rs   = 1'($urandom_range(0, 1));
            run_op(ra, rs, ramt, ref_shift(ra, rs, ramt), 0);
        end

        repeat (3) @(negedge clock);
        chk_eq("rdy_count", rdy_cnt, n_start);
        chk_eq("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
